// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one fpu between N_REQ requesters.
// Requests are granted round-robin. The winner's operands are latched and
// presented to the fpu through an order/accepted/done handshake. The result
// goes back to the owner with a one-cycle done pulse.
module fpu_arbiter #(
   parameter int N_REQ = 2,
   parameter int ID_W  = 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [N_REQ-1:0]      req_order,
   input  logic [3*N_REQ-1:0]    req_func3,
   input  logic [7*N_REQ-1:0]    req_func7,
   input  logic [32*N_REQ-1:0]   req_rs1,
   input  logic [32*N_REQ-1:0]   req_rs2,
   output logic [N_REQ-1:0]      req_accepted,
   output logic [N_REQ-1:0]      req_done,
   output logic [31:0]           rd,
   output logic                  busy,
   output logic                  fpu_order,
   output logic [2:0]            fpu_func3,
   output logic [6:0]            fpu_func7,
   output logic [31:0]           fpu_rs1,
   output logic [31:0]           fpu_rs2,
   input  logic                  fpu_accepted,
   input  logic                  fpu_done,
   input  logic [31:0]           fpu_rd
);

   // One extra bit so that pointer + offset can exceed N_REQ before wrapping.
   localparam int CW = ID_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [ID_W-1:0]     ptr_q;
   logic [ID_W-1:0]     owner_q;
   logic [2:0]          func3_q;
   logic [6:0]          func7_q;
   logic [31:0]         rs1_q;
   logic [31:0]         rs2_q;
   logic [31:0]         rd_q;
   logic [N_REQ-1:0]    acc_q;
   logic [N_REQ-1:0]    done_q;

   logic                win_valid_s;
   logic [ID_W-1:0]     win_id_s;
   logic [CW-1:0]       cand_s;
   logic [ID_W-1:0]     ptr_nxt_s;
   logic [2:0]          win_func3_s;
   logic [6:0]          win_func7_s;
   logic [31:0]         win_rs1_s;
   logic [31:0]         win_rs2_s;
   logic                fpu_order_s;
   logic                busy_s;

   // Convert a requester index into a one-hot vector.
   function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
      logic [N_REQ-1:0] oh;
      oh = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (id == ID_W'(i)) begin
            oh[i] = 1'b1;
         end else begin
            oh[i] = 1'b0;
         end
      end
      return oh;
   endfunction

   // Round-robin search: first requesting index at or after the pointer, wrapping.
   always_comb begin
      win_valid_s = 1'b0;
      win_id_s    = '0;
      cand_s      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand_s = {1'b0, ptr_q} + CW'(k);
         if (cand_s >= CW'(N_REQ)) begin
            cand_s = cand_s - CW'(N_REQ);
         end else begin
            cand_s = cand_s;
         end
         for (int i = 0; i < N_REQ; i++) begin
            if (!win_valid_s && req_order[i] && (cand_s == CW'(i))) begin
               win_valid_s = 1'b1;
               win_id_s    = ID_W'(i);
            end else begin
               win_valid_s = win_valid_s;
            end
         end
      end
   end

   // Pointer value after a grant: the requester following the winner.
   always_comb begin
      if (win_id_s == ID_W'(N_REQ - 1)) begin
         ptr_nxt_s = '0;
      end else begin
         ptr_nxt_s = win_id_s + ID_W'(1);
      end
   end

   // Select the winner's operand slices from the packed request buses.
   always_comb begin
      win_func3_s = 3'd0;
      win_func7_s = 7'd0;
      win_rs1_s   = 32'd0;
      win_rs2_s   = 32'd0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_id_s == ID_W'(i)) begin
            win_func3_s = req_func3[i*3 +: 3];
            win_func7_s = req_func7[i*7 +: 7];
            win_rs1_s   = req_rs1[i*32 +: 32];
            win_rs2_s   = req_rs2[i*32 +: 32];
         end else begin
            win_func3_s = win_func3_s;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a done in ISSUE wins over accepted and skips WAIT.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (win_valid_s) begin
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (fpu_done) begin
               state_d = IDLE;
            end else if (fpu_accepted) begin
               state_d = WAIT;
            end else begin
               state_d = ISSUE;
            end
         end
         WAIT: begin
            if (fpu_done) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode; order must be low in WAIT or the fpu restarts after done.
   always_comb begin
      fpu_order_s = 1'b0;
      busy_s      = 1'b0;
      case (state_q)
         IDLE: begin
            fpu_order_s = 1'b0;
            busy_s      = 1'b0;
         end
         ISSUE: begin
            fpu_order_s = 1'b1;
            busy_s      = 1'b1;
         end
         WAIT: begin
            fpu_order_s = 1'b0;
            busy_s      = 1'b1;
         end
         default: begin
            fpu_order_s = 1'b0;
            busy_s      = 1'b0;
         end
      endcase
   end

   // Datapath: latch winner operands, pointer, result and the one-cycle pulses.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr_q   <= '0;
         owner_q <= '0;
         func3_q <= 3'd0;
         func7_q <= 7'd0;
         rs1_q   <= 32'd0;
         rs2_q   <= 32'd0;
         rd_q    <= 32'd0;
         acc_q   <= '0;
         done_q  <= '0;
      end else begin
         acc_q  <= '0;
         done_q <= '0;
         case (state_q)
            IDLE: begin
               if (win_valid_s) begin
                  owner_q <= win_id_s;
                  func3_q <= win_func3_s;
                  func7_q <= win_func7_s;
                  rs1_q   <= win_rs1_s;
                  rs2_q   <= win_rs2_s;
                  ptr_q   <= ptr_nxt_s;
                  acc_q   <= id_to_onehot(win_id_s);
               end
            end
            ISSUE, WAIT: begin
               if (fpu_done) begin
                  rd_q   <= fpu_rd;
                  done_q <= id_to_onehot(owner_q);
               end
            end
            default: begin
               acc_q  <= '0;
               done_q <= '0;
            end
         endcase
      end
   end

   assign req_accepted = acc_q;
   assign req_done     = done_q;
   assign rd           = rd_q;
   assign busy         = busy_s;
   assign fpu_order    = fpu_order_s;
   assign fpu_func3    = func3_q;
   assign fpu_func7    = func7_q;
   assign fpu_rs1      = rs1_q;
   assign fpu_rs2      = rs2_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Randomized bench for fpu_arbiter with a transaction-level reference model
// and a simple behavioural fpu.
module tb_fpu_arbiter;

   localparam int N_REQ = 2;
   localparam int ID_W  = 1;
   localparam logic [6:0] F7_FMVI = 7'h78;
   localparam logic [6:0] F7_FADD = 7'h00;
   localparam logic [6:0] F7_FMUL = 7'h08;
   localparam logic [6:0] F7_BAD  = 7'h7F;

   logic                 clk;
   logic                 rstn;
   logic [N_REQ-1:0]     req_order;
   logic [3*N_REQ-1:0]   req_func3;
   logic [7*N_REQ-1:0]   req_func7;
   logic [32*N_REQ-1:0]  req_rs1;
   logic [32*N_REQ-1:0]  req_rs2;
   logic [N_REQ-1:0]     req_accepted;
   logic [N_REQ-1:0]     req_done;
   logic [31:0]          rd;
   logic                 busy;
   logic                 fpu_order;
   logic [2:0]           fpu_func3;
   logic [6:0]           fpu_func7;
   logic [31:0]          fpu_rs1;
   logic [31:0]          fpu_rs2;
   logic                 fpu_accepted;
   logic                 fpu_done;
   logic [31:0]          fpu_rd;

   fpu_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
      .clk(clk), .rstn(rstn),
      .req_order(req_order), .req_func3(req_func3), .req_func7(req_func7),
      .req_rs1(req_rs1), .req_rs2(req_rs2),
      .req_accepted(req_accepted), .req_done(req_done), .rd(rd), .busy(busy),
      .fpu_order(fpu_order), .fpu_func3(fpu_func3), .fpu_func7(fpu_func7),
      .fpu_rs1(fpu_rs1), .fpu_rs2(fpu_rs2),
      .fpu_accepted(fpu_accepted), .fpu_done(fpu_done), .fpu_rd(fpu_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // requester side
   bit          pending [N_REQ];
   logic [2:0]  op_f3   [N_REQ];
   logic [6:0]  op_f7   [N_REQ];
   logic [31:0] op_rs1  [N_REQ];
   logic [31:0] op_rs2  [N_REQ];
   logic [6:0]  fl_f7   [N_REQ];
   logic [31:0] fl_rs1  [N_REQ];
   logic [31:0] fl_rs2  [N_REQ];
   bit          auto_req;
   int          req_rate;

   // reference model: one outstanding operation, round-robin pointer
   bit               m_busy, m_iss;
   int               m_owner, m_ptr;
   logic [2:0]       m_f3;
   logic [6:0]       m_f7;
   logic [31:0]      m_rs1, m_rs2, m_rd;
   logic [N_REQ-1:0] exp_acc, exp_done;

   // fpu model
   bit          f_run, f_acc, cfg_rand, force_spur;
   int          f_lat, f_adly, cfg_lat, cfg_adly;
   logic [31:0] f_res;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Stand-in fpu arithmetic; only FADD 1.0+2.0 is real IEEE.
   function automatic logic [31:0] fpu_fn(input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
      case (f7)
         F7_FMVI: return a;
         F7_FADD: return (a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000 : a + b;
         F7_FMUL: return a ^ b;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [6:0] rand_f7();
      case ($urandom_range(0, 3))
         0: return F7_FMVI;
         1: return F7_FADD;
         2: return F7_FMUL;
         default: return F7_BAD;
      endcase
   endfunction

   task automatic clear_all();
      m_busy = 0; m_iss = 0; m_owner = 0; m_ptr = 0;
      m_f3 = '0; m_f7 = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
      exp_acc = '0; exp_done = '0;
      f_run = 0; f_acc = 0; force_spur = 0;
      for (int i = 0; i < N_REQ; i++) pending[i] = 0;
      req_order = '0; req_func3 = '0; req_func7 = '0; req_rs1 = '0; req_rs2 = '0;
      fpu_accepted = 1'b0; fpu_done = 1'b0; fpu_rd = 32'h0;
   endtask

   task automatic fpu_drive();
      fpu_accepted = 1'b0;
      fpu_done     = 1'b0;
      fpu_rd       = $urandom;
      if (force_spur) begin
         force_spur = 0;
         fpu_done   = 1'b1;
         fpu_rd     = 32'hDEADBEEF;
         if (!busy) $display("note: fpu_done while arbiter idle (protocol error)");
      end else begin
         if (!f_run && fpu_order) begin
            f_run = 1; f_acc = 0;
            f_res = fpu_fn(fpu_func7, fpu_rs1, fpu_rs2);
            if (cfg_rand) begin
               f_lat  = $urandom_range(0, 3);
               f_adly = $urandom_range(0, 2);
            end else begin
               f_lat  = cfg_lat;
               f_adly = cfg_adly;
            end
         end
         if (f_run) begin
            if (!f_acc) begin
               if (f_lat == 0) begin
                  fpu_done = 1'b1; fpu_rd = f_res; f_run = 0;
                  fpu_accepted = 1'($urandom_range(0, 1));
               end else if (f_adly == 0) begin
                  fpu_accepted = 1'b1; f_acc = 1;
               end else begin
                  f_adly--;
               end
            end else begin
               check_eq("order_after_accept", 32'(fpu_order), 32'd0);
               f_lat--;
               if (f_lat == 0) begin
                  fpu_done = 1'b1; fpu_rd = f_res; f_run = 0;
               end
            end
         end
      end
   endtask

   // Predict next-cycle outputs from the inputs now on the pins.
   task automatic predict();
      int  w;
      bit  found;
      exp_acc  = '0;
      exp_done = '0;
      if (!m_busy) begin
         found = 0; w = 0;
         for (int d = 0; d < N_REQ; d++) begin
            if (!found && req_order[(m_ptr + d) % N_REQ]) begin
               found = 1; w = (m_ptr + d) % N_REQ;
            end
         end
         if (found) begin
            m_busy = 1; m_iss = 1; m_owner = w;
            m_f3 = op_f3[w]; m_f7 = op_f7[w]; m_rs1 = op_rs1[w]; m_rs2 = op_rs2[w];
            m_ptr = (w + 1) % N_REQ;
            exp_acc[w] = 1'b1;
         end
      end else if (fpu_done) begin
         m_rd = fpu_rd;
         exp_done[m_owner] = 1'b1;
         m_busy = 0;
      end else if (m_iss && fpu_accepted) begin
         m_iss = 0;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_eq("accepted", 32'(req_accepted), 32'(exp_acc));
      check_eq("done", 32'(req_done), 32'(exp_done));
      check_eq("rd", rd, m_rd);
      check_eq("busy", 32'(busy), 32'(m_busy));
      check_eq("fpu_order", 32'(fpu_order), 32'(m_busy && m_iss));
      check_eq("fpu_rs1", fpu_rs1, m_rs1);
      check_eq("fpu_rs2", fpu_rs2, m_rs2);
      check_eq("fpu_f3f7", {22'd0, fpu_func3, fpu_func7}, {22'd0, m_f3, m_f7});
      for (int i = 0; i < N_REQ; i++) begin
         if (exp_acc[i]) begin
            pending[i] = 0;
            fl_f7[i] = op_f7[i]; fl_rs1[i] = op_rs1[i]; fl_rs2[i] = op_rs2[i];
         end
         if (exp_done[i]) check_eq("e2e_rd", rd, fpu_fn(fl_f7[i], fl_rs1[i], fl_rs2[i]));
      end
      if (auto_req) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!pending[i] && $urandom_range(0, 99) < req_rate) begin
               pending[i] = 1;
               op_f3[i] = 3'($urandom); op_f7[i] = rand_f7();
               op_rs1[i] = $urandom; op_rs2[i] = $urandom;
            end
         end
      end
      // Idle requesters scribble on their operand lanes.
      for (int i = 0; i < N_REQ; i++) begin
         req_order[i] = pending[i];
         req_func3[i*3 +: 3]   = pending[i] ? op_f3[i]  : 3'($urandom);
         req_func7[i*7 +: 7]   = pending[i] ? op_f7[i]  : 7'($urandom);
         req_rs1[i*32 +: 32]   = pending[i] ? op_rs1[i] : $urandom;
         req_rs2[i*32 +: 32]   = pending[i] ? op_rs2[i] : $urandom;
      end
      fpu_drive();
      predict();
   endtask

   task automatic set_op(input int i, input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
      pending[i] = 1; op_f3[i] = 3'd0; op_f7[i] = f7; op_rs1[i] = a; op_rs2[i] = b;
   endtask

   task automatic drain();
      bit any;
      for (int k = 0; k < 100; k++) begin
         any = m_busy;
         for (int i = 0; i < N_REQ; i++) any = any | pending[i];
         if (any) tick();
      end
      tick();
      check_eq("drain_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      rstn = 1'b0;
      clear_all();
      auto_req = 0; req_rate = 0; cfg_rand = 0; cfg_lat = 0; cfg_adly = 0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      // single-cycle FMVI from requester 0
      set_op(0, F7_FMVI, 32'h3F800000, 32'h12345678);
      cfg_lat = 0;
      repeat (4) tick();
      check_eq("single_rd", rd, 32'h3F800000);

      // multi-cycle FADD from requester 1, done 3 cycles after accept
      set_op(1, F7_FADD, 32'h3F800000, 32'h40000000);
      cfg_lat = 3; cfg_adly = 0;
      repeat (8) tick();
      check_eq("fadd_rd", rd, 32'h40400000);

      // delayed accept, then reset while waiting on the fpu
      set_op(0, F7_FMUL, 32'hA5A5A5A5, 32'h0F0F0F0F);
      cfg_lat = 8; cfg_adly = 1;
      repeat (4) tick();
      check_eq("pre_reset_busy", 32'(busy), 32'd1);
      rstn = 1'b0;
      #1;
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_rd", rd, 32'd0);
      check_eq("rst_done", 32'(req_done), 32'd0);
      check_eq("rst_order", 32'(fpu_order), 32'd0);
      check_eq("rst_rs1", fpu_rs1, 32'd0);
      clear_all();
      @(negedge clk);
      rstn = 1'b1;
      // both request together: pointer restarts at requester 0
      set_op(0, F7_FMVI, 32'h11111111, 32'h0);
      set_op(1, F7_FMVI, 32'h22222222, 32'h0);
      cfg_lat = 0;
      drain();

      // spurious done in IDLE
      force_spur = 1;
      tick();
      tick();
      check_eq("spur_done", 32'(req_done), 32'd0);
      check_eq("spur_rd", rd, 32'h22222222);

      // contention: both requesters always asking
      auto_req = 1; req_rate = 100; cfg_rand = 1;
      repeat (200) tick();

      // general random traffic
      req_rate = 30;
      repeat (1500) tick();
      auto_req = 0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
